// File: rtl/sram_ctrl.sv
// Single-port SRAM controller with credit-gated read-response FIFO.
// Define SRAM_CTRL_RMW_EN to merge partial-strobe writes via read-modify-write.
module sram_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                sram_cs,
    output logic                sram_web,
    output logic                sram_oe,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [DATA_W-1:0] mem_d [RSP_DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_pend_q, rd_pend_d;
    logic [CW-1:0]     credit;
    logic              idle, fire, push, pop;

`ifdef SRAM_CTRL_RMW_EN
    localparam int NB = DATA_W / 8;

    typedef enum logic {IDLE, RMW} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
    logic [NB-1:0]     rmw_strb_q, rmw_strb_d;

    assign idle = (state_q == IDLE);
`else
    assign idle = 1'b1;
`endif

    assign sram_oe   = 1'b1;
    assign rsp_valid = !rst && (count_q != '0);
    assign rsp_data  = rsp_valid ? mem_q[rptr_q] : '0;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = rd_pend_q && !rst;
    // Slots claimed: buffered plus the read still coming back, minus the one leaving.
    assign credit    = count_q + CW'(rd_pend_q) - CW'(pop);
    assign req_ready = !rst && idle && (credit < CW'(RSP_DEPTH));
    assign fire      = req_valid && req_ready;

    always_comb begin
        sram_cs   = 1'b0;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_di   = '0;
        rd_pend_d = 1'b0;
`ifdef SRAM_CTRL_RMW_EN
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_strb_d  = rmw_strb_q;
`endif
        if (fire && !req_write) begin
            sram_cs   = 1'b1;
            sram_a    = req_addr;
            rd_pend_d = 1'b1;
        end else if (fire && (req_wstrb != '0)) begin
            sram_cs = 1'b1;
            sram_a  = req_addr;
`ifdef SRAM_CTRL_RMW_EN
            if (&req_wstrb) begin
                sram_web = 1'b0;
                sram_di  = req_wdata;
            end else begin
                state_d     = RMW;
                rmw_addr_d  = req_addr;
                rmw_wdata_d = req_wdata;
                rmw_strb_d  = req_wstrb;
            end
`else
            sram_web = 1'b0;
            sram_di  = req_wdata;
`endif
        end
`ifdef SRAM_CTRL_RMW_EN
        if (state_q == RMW) begin
            sram_cs  = 1'b1;
            sram_web = 1'b0;
            sram_a   = rmw_addr_q;
            state_d  = IDLE;
            for (int b = 0; b < NB; b++) begin
                sram_di[b*8 +: 8] = rmw_strb_q[b] ? rmw_wdata_q[b*8 +: 8]
                                                  : sram_do[b*8 +: 8];
            end
        end
`endif
        if (rst) begin
            sram_cs  = 1'b0;
            sram_web = 1'b1;
            sram_a   = '0;
            sram_di  = '0;
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = sram_do;
            wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
`ifdef SRAM_CTRL_RMW_EN
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_strb_q  <= '0;
`endif
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
`ifdef SRAM_CTRL_RMW_EN
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_strb_q  <= rmw_strb_d;
`endif
        end
        mem_q <= mem_d;
    end

endmodule
